// File: rtl/smallcalc_cu_param.sv
// smallcalc_cu_param: control unit for the small-calculator datapath.
// Sequences operand loads, decode, single- or multi-cycle execute,
// write-back and result read-out. Operations are started and finished
// with a four-phase go/done handshake. Illegal opcodes and ALU timeouts
// end in an error state.
module smallcalc_cu_param #(
  parameter int AW      = 2,
  parameter int OPW     = 3,
  parameter int NUM_OPS = 6,
  parameter int TO_CYC  = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [OPW-1:0] op,
  input  logic [AW-1:0]  srca,
  input  logic [AW-1:0]  srcb,
  input  logic [AW-1:0]  dst,
  input  logic           alu_done,
  output logic           we,
  output logic [AW-1:0]  wa,
  output logic           rea,
  output logic [AW-1:0]  raa,
  output logic           reb,
  output logic [AW-1:0]  rab,
  output logic [1:0]     s1,
  output logic [OPW-1:0] c,
  output logic           alu_start,
  output logic           s2,
  output logic           done,
  output logic           busy,
  output logic           err,
  output logic [3:0]     cs
);

  // The timeout counter only has to reach TO_CYC-1.
  localparam int          CW      = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

  localparam logic [1:0] S1_EXTA = 2'b00;
  localparam logic [1:0] S1_EXTB = 2'b01;
  localparam logic [1:0] S1_NONE = 2'b10;
  localparam logic [1:0] S1_ALU  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LD1   = 4'd1,
    S_LD2   = 4'd2,
    S_DEC   = 4'd3,
    S_EXEC  = 4'd4,
    S_MWAIT = 4'd5,
    S_WB    = 4'd6,
    S_DONE  = 4'd7,
    S_ERR   = 4'd8
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [OPW-1:0] op_q;
  logic [AW-1:0]  srca_q;
  logic [AW-1:0]  srcb_q;
  logic [AW-1:0]  dst_q;
  logic [CW-1:0]  cnt;
  logic           op_multi;
  logic           op_illegal;

  assign op_multi   = op_q[OPW-1];
  assign op_illegal = (int'(op_q) >= NUM_OPS);

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operation fields are captured only when a request is accepted in IDLE,
  // so input changes during an operation cannot disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      srca_q <= '0;
      srcb_q <= '0;
      dst_q  <= '0;
    end else if (state == S_IDLE && go) begin
      op_q   <= op;
      srca_q <= srca;
      srcb_q <= srcb;
      dst_q  <= dst;
    end
  end

  // Timeout counter: zeroed while in EXEC so it starts at 0 in the first
  // MWAIT cycle, then counts MWAIT cycles without alu_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == S_EXEC) begin
      cnt <= '0;
    end else if (state == S_MWAIT && !alu_done && cnt != TO_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Next-state logic; alu_done takes priority over the timeout.
  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = go ? S_LD1 : S_IDLE;
      S_LD1:   state_next = S_LD2;
      S_LD2:   state_next = S_DEC;
      S_DEC:   state_next = op_illegal ? S_ERR : S_EXEC;
      S_EXEC:  state_next = op_multi ? S_MWAIT : S_DONE;
      S_MWAIT: begin
        if (alu_done) begin
          state_next = S_WB;
        end else if (cnt == TO_LAST) begin
          state_next = S_ERR;
        end else begin
          state_next = S_MWAIT;
        end
      end
      S_WB:    state_next = S_DONE;
      S_DONE:  state_next = go ? S_DONE : S_IDLE;
      S_ERR:   state_next = go ? S_ERR : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore output decode from the current state and captured fields.
  always_comb begin
    we        = 1'b0;
    wa        = '0;
    rea       = 1'b0;
    raa       = '0;
    reb       = 1'b0;
    rab       = '0;
    s1        = S1_NONE;
    c         = '0;
    alu_start = 1'b0;
    s2        = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state != S_IDLE);
    cs        = state;
    case (state)
      S_LD1: begin
        we = 1'b1;
        wa = srca_q;
        s1 = S1_EXTA;
      end
      S_LD2: begin
        we = 1'b1;
        wa = srcb_q;
        s1 = S1_EXTB;
      end
      S_EXEC, S_MWAIT, S_WB: begin
        rea = 1'b1;
        raa = srca_q;
        reb = 1'b1;
        rab = srcb_q;
        c   = op_q;
        s1  = S1_ALU;
        if (state == S_EXEC && !op_multi) begin
          we = 1'b1;
          wa = dst_q;
        end
        if (state == S_EXEC && op_multi) begin
          alu_start = 1'b1;
        end
        if (state == S_WB) begin
          we = 1'b1;
          wa = dst_q;
        end
      end
      S_DONE: begin
        rea  = 1'b1;
        raa  = dst_q;
        s2   = 1'b1;
        done = 1'b1;
      end
      S_ERR: begin
        err  = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_smallcalc_cu_param.sv
// Testbench for smallcalc_cu_param: transaction-level timing model checked
// every cycle, plus directed runs with hand-computed expectations.
module tb_smallcalc_cu_param;

  localparam int AW      = 2;
  localparam int OPW     = 3;
  localparam int NUM_OPS = 6;
  localparam int TO_CYC  = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           go = 1'b0;
  logic [OPW-1:0] op = '0;
  logic [AW-1:0]  srca = '0;
  logic [AW-1:0]  srcb = '0;
  logic [AW-1:0]  dst = '0;
  logic           alu_done = 1'b0;
  logic           we, rea, reb, alu_start, s2, done, busy, err;
  logic [AW-1:0]  wa, raa, rab;
  logic [1:0]     s1;
  logic [OPW-1:0] c;
  logic [3:0]     cs;

  typedef struct packed {
    logic           we;
    logic [AW-1:0]  wa;
    logic           rea;
    logic [AW-1:0]  raa;
    logic           reb;
    logic [AW-1:0]  rab;
    logic [1:0]     s1;
    logic [OPW-1:0] c;
    logic           alu_start;
    logic           s2;
    logic           done;
    logic           busy;
    logic           err;
    logic [3:0]     cs;
  } out_t;

  int checks = 0;
  int errors = 0;
  out_t trace[$];

  smallcalc_cu_param #(.AW(AW), .OPW(OPW), .NUM_OPS(NUM_OPS), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .go(go), .op(op), .srca(srca), .srcb(srcb),
    .dst(dst), .alu_done(alu_done), .we(we), .wa(wa), .rea(rea), .raa(raa),
    .reb(reb), .rab(rab), .s1(s1), .c(c), .alu_start(alu_start), .s2(s2),
    .done(done), .busy(busy), .err(err), .cs(cs)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Model: an operation is described by the number of cycles since the
  // accepting edge, the opcode class and when alu_done was first seen.
  int             m_cs = 0;
  int             m_t = 0;
  int             m_k = -1;
  logic [OPW-1:0] m_op = '0;
  logic [AW-1:0]  m_a = '0, m_b = '0, m_d = '0;

  function automatic int phaseAt(int t);
    int j;
    if (t < 3) return t + 1;
    if (int'(m_op) >= NUM_OPS) return 8;
    if (t == 3) return 4;
    if (!m_op[OPW-1]) return 7;
    j = t - 4;
    if (m_k >= 0) return (j == m_k + 1) ? 6 : 7;
    return (j < TO_CYC) ? 5 : 8;
  endfunction

  // Advance the model at each rising edge; reset is honoured at once.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cs = 0; m_t = 0; m_k = -1;
      m_op = '0; m_a = '0; m_b = '0; m_d = '0;
    end else if (m_cs == 0) begin
      if (go) begin
        m_op = op; m_a = srca; m_b = srcb; m_d = dst;
        m_t = 0; m_k = -1; m_cs = 1;
      end
    end else if (m_cs == 7 || m_cs == 8) begin
      if (!go) m_cs = 0;
    end else begin
      if (m_cs == 5 && m_k < 0 && alu_done) m_k = m_t - 4;
      m_t = m_t + 1;
      m_cs = phaseAt(m_t);
    end
  end

  function automatic out_t expectedOut(int st);
    out_t o;
    o = '0;
    o.s1 = 2'b10;
    o.cs = 4'(st);
    o.busy = (st != 0);
    if (st == 1) begin o.we = 1; o.wa = m_a; o.s1 = 2'b00; end
    if (st == 2) begin o.we = 1; o.wa = m_b; o.s1 = 2'b01; end
    if (st >= 4 && st <= 6) begin
      o.rea = 1; o.raa = m_a; o.reb = 1; o.rab = m_b; o.c = m_op; o.s1 = 2'b11;
    end
    if ((st == 4 && !m_op[OPW-1]) || st == 6) begin o.we = 1; o.wa = m_d; end
    if (st == 4 && m_op[OPW-1]) o.alu_start = 1;
    if (st == 7) begin o.rea = 1; o.raa = m_d; o.s2 = 1; o.done = 1; end
    if (st == 8) begin o.err = 1; o.done = 1; end
    return o;
  endfunction

  function automatic out_t cur();
    out_t o;
    o = {we, wa, rea, raa, reb, rab, s1, c, alu_start, s2, done, busy, err, cs};
    return o;
  endfunction

  // Every falling edge: compare all DUT outputs against the model.
  always @(negedge clk) begin
    out_t e, a;
    e = expectedOut(m_cs);
    a = cur();
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL model_compare t=%0t actual=%h required=%h (cs %0d vs %0d)",
               $time, a, e, a.cs, e.cs);
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [OPW-1:0] o, input logic [AW-1:0] a,
                               input logic [AW-1:0] b, input logic [AW-1:0] d);
    tick();
    op = o; srca = a; srcb = b; dst = d; go = 1'b1;
  endtask

  // Run one operation, recording outputs after each edge until DONE/ERR.
  // alu_done is raised for the k-th MWAIT cycle (k<0: never).
  task automatic runOp(input logic [OPW-1:0] o, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [AW-1:0] d,
                       input int k, input int budget);
    int mw;
    bit fin;
    applyStimulus(o, a, b, d);
    trace.delete();
    mw = 0;
    fin = 0;
    for (int i = 0; i < budget && !fin; i++) begin
      tick();
      trace.push_back(cur());
      alu_done = 1'b0;
      if (cs == 4'd5) begin
        if (mw == k) alu_done = 1'b1;
        mw++;
      end
      if (cs == 4'd7 || cs == 4'd8) fin = 1;
    end
    alu_done = 1'b0;
    if (!fin) checkOutput("run_budget_expired", 0, 1);
  endtask

  task automatic dropGo();
    go = 1'b0;
    tick();
    checkOutput("idle_after_go_drop", int'(cs), 0);
  endtask

  task automatic checkSeq(input string name, input int exp[]);
    checkOutput({name, "_len"}, trace.size(), exp.size());
    for (int i = 0; i < exp.size() && i < trace.size(); i++)
      checkOutput($sformatf("%s_cs%0d", name, i), int'(trace[i].cs), exp[i]);
  endtask

  function automatic int countMwait();
    int n = 0;
    foreach (trace[i]) if (trace[i].cs == 4'd5) n++;
    return n;
  endfunction

  function automatic int countStart();
    int n = 0;
    foreach (trace[i]) if (trace[i].alu_start) n++;
    return n;
  endfunction

  initial begin
    out_t idle_v;
    idle_v = '0;
    idle_v.s1 = 2'b10;

    #1 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("reset_cs", int'(cs), 0);
    checkOutput("reset_outputs", int'(cur() == idle_v), 1);

    // Reset asserted in the middle of EXEC.
    applyStimulus(3'd0, 2'd1, 2'd2, 2'd3);
    repeat (4) tick();
    checkOutput("pre_reset_exec", int'(cs), 4);
    #2 rst = 1'b0;
    go = 1'b0;
    #1;
    checkOutput("async_reset_cs", int'(cs), 0);
    checkOutput("async_reset_outputs", int'(cur() == idle_v), 1);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("post_reset_idle", int'(cs), 0);

    // ADD, single cycle.
    runOp(3'd0, 2'd1, 2'd2, 2'd3, -1, 10);
    checkSeq("add", '{1, 2, 3, 4, 7});
    checkOutput("add_ld1_wa", int'(trace[0].wa), 1);
    checkOutput("add_ld2_wa", int'(trace[1].wa), 2);
    checkOutput("add_exec_we", int'(trace[3].we), 1);
    checkOutput("add_exec_wa", int'(trace[3].wa), 3);
    checkOutput("add_exec_c", int'(trace[3].c), 0);
    checkOutput("add_done", int'(trace[4].done), 1);
    checkOutput("add_raa", int'(trace[4].raa), 3);
    repeat (2) tick();
    checkOutput("add_done_held", int'(done), 1);
    dropGo();

    // MUL, multi cycle, alu_done three cycles into MWAIT.
    runOp(3'd4, 2'd1, 2'd2, 2'd0, 3, 20);
    checkSeq("mul", '{1, 2, 3, 4, 5, 5, 5, 5, 6, 7});
    checkOutput("mul_start_exec", int'(trace[3].alu_start), 1);
    checkOutput("mul_start_count", countStart(), 1);
    checkOutput("mul_wb_we", int'(trace[8].we), 1);
    checkOutput("mul_wb_wa", int'(trace[8].wa), 0);
    dropGo();

    // Alias: both operand loads target register 2.
    runOp(3'd4, 2'd2, 2'd2, 2'd1, 0, 20);
    checkSeq("alias", '{1, 2, 3, 4, 5, 6, 7});
    checkOutput("alias_ld1_wa", int'(trace[0].wa), 2);
    checkOutput("alias_ld2_wa", int'(trace[1].wa), 2);
    dropGo();

    // Timeout with alu_done never seen.
    runOp(3'd5, 2'd0, 2'd1, 2'd2, -1, 40);
    checkOutput("to_len", trace.size(), 20);
    checkOutput("to_mwait_cycles", countMwait(), 15);
    checkOutput("to_err_cs", int'(trace[trace.size()-1].cs), 8);
    checkOutput("to_err", int'(trace[trace.size()-1].err), 1);
    checkOutput("to_done", int'(trace[trace.size()-1].done), 1);
    checkOutput("to_we", int'(trace[trace.size()-1].we), 0);
    dropGo();

    // alu_done on the last allowed MWAIT cycle wins over the timeout.
    runOp(3'd5, 2'd0, 2'd1, 2'd2, 14, 40);
    checkOutput("to_edge_len", trace.size(), 21);
    checkOutput("to_edge_mwait", countMwait(), 15);
    if (trace.size() == 21) checkOutput("to_edge_wb", int'(trace[19].cs), 6);
    checkOutput("to_edge_final", int'(trace[trace.size()-1].cs), 7);
    dropGo();

    // Illegal opcodes.
    runOp(3'd6, 2'd1, 2'd2, 2'd3, -1, 10);
    checkSeq("ill6", '{1, 2, 3, 8});
    checkOutput("ill6_dec_we", int'(trace[2].we), 0);
    checkOutput("ill6_err_we", int'(trace[3].we), 0);
    checkOutput("ill6_err", int'(trace[3].err), 1);
    dropGo();
    runOp(3'd7, 2'd1, 2'd2, 2'd3, -1, 10);
    checkSeq("ill7", '{1, 2, 3, 8});
    dropGo();

    // Input changes and go toggling mid-operation.
    applyStimulus(3'd0, 2'd1, 2'd2, 2'd3);
    tick();
    checkOutput("mid_ld1", int'(cs), 1);
    op = 3'd4; dst = 2'd0; srca = 2'd3; go = 1'b0;
    tick();
    checkOutput("mid_ld2", int'(cs), 2);
    checkOutput("mid_ld2_wa", int'(wa), 2);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    checkOutput("mid_exec", int'(cs), 4);
    checkOutput("mid_exec_c", int'(c), 0);
    checkOutput("mid_exec_wa", int'(wa), 3);
    checkOutput("mid_exec_start", int'(alu_start), 0);
    go = 1'b1;
    tick();
    checkOutput("mid_done", int'(cs), 7);
    checkOutput("mid_done_raa", int'(raa), 3);
    repeat (3) tick();
    checkOutput("mid_done_hold", int'(cs), 7);
    dropGo();
    tick();
    checkOutput("mid_stay_idle", int'(cs), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog in case the stimulus sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
